// File: rtl/note_sequencer_if.sv
//==============================================================================
// Module      : note_sequencer_if
// Description : Control/status bundle between a note_sequencer and its host.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface note_sequencer_if;
  logic        start;
  logic        stop;
  logic        mode;
  logic [31:0] div_in;
  logic        tone_out;
  logic        busy;
  logic [2:0]  note_idx;
  logic        done;

  modport master (
    output start, stop, mode, div_in,
    input  tone_out, busy, note_idx, done
  );

  modport slave (
    input  start, stop, mode, div_in,
    output tone_out, busy, note_idx, done
  );
endinterface

`default_nettype wire

// File: rtl/note_sequencer.sv
//==============================================================================
// Module      : note_sequencer
// Description : Square-wave tone generator with manual divisor or automatic
//               8-note scale playback. Define NOTE_SEQ_LOOP_EN to repeat the
//               scale until stopped.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module note_sequencer #(
  parameter int unsigned DUR_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  wire                    CLOCK_50,
  input  wire                    reset_n,
  note_sequencer_if.slave        sif
);

  localparam logic [31:0] c_dur_last = 32'(DUR_CYCLES - 1);
  localparam logic [31:0] c_gap_last = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_PLAY   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_half;
  logic [31:0] r_cnt;
  logic [31:0] r_div_prev;
  logic [2:0]  r_note_idx;
  logic        r_tone;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_rom;
  logic [31:0] w_div;
  logic        w_div_chg;

  always_comb begin
    w_rom = 32'd0;
    case (r_note_idx)
      3'd0: w_rom = 32'h0000_BA9E;
      3'd1: w_rom = 32'h0000_A65A;
      3'd2: w_rom = 32'h0000_942D;
      3'd3: w_rom = 32'h0000_8BE6;
      3'd4: w_rom = 32'h0000_7C8D;
      3'd5: w_rom = 32'h0000_6EF7;
      3'd6: w_rom = 32'h0000_62DB;
      3'd7: w_rom = 32'h0000_5D50;
      default: w_rom = 32'd0;
    endcase
  end

  always_comb begin
    w_div     = (r_state == S_MANUAL) ? sif.div_in : w_rom;
    w_div_chg = (r_state == S_MANUAL) && (sif.div_in != r_div_prev);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_half     <= 32'd0;
      r_cnt      <= 32'd0;
      r_div_prev <= 32'd0;
      r_note_idx <= 3'd0;
      r_tone     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_div_prev <= sif.div_in;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tone <= 1'b0;
          r_half <= 32'd0;
          r_cnt  <= 32'd0;
          // stop outranks a simultaneous start
          if (sif.start && !sif.stop) begin
            r_busy <= 1'b1;
            if (sif.mode) begin
              r_state    <= S_PLAY;
              r_note_idx <= 3'd0;
            end else begin
              r_state <= S_MANUAL;
            end
          end
        end

        S_MANUAL, S_PLAY: begin
          if (sif.stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tone  <= 1'b0;
            r_half  <= 32'd0;
            r_cnt   <= 32'd0;
          end else begin
            // a new manual divisor restarts the half period, level held
            if (w_div == 32'd0) begin
              r_half <= 32'd0;
              r_tone <= 1'b0;
            end else if (w_div_chg) begin
              r_half <= 32'd0;
            end else if (r_half == w_div - 32'd1) begin
              r_half <= 32'd0;
              r_tone <= ~r_tone;
            end else begin
              r_half <= r_half + 32'd1;
            end
            if (r_state == S_PLAY) begin
              if (r_cnt == c_dur_last) begin
                r_state <= S_GAP;
                r_cnt   <= 32'd0;
                r_half  <= 32'd0;
                r_tone  <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          end
        end

        S_GAP: begin
          r_tone <= 1'b0;
          r_half <= 32'd0;
          if (sif.stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 32'd0;
          end else if (r_cnt == c_gap_last) begin
            r_cnt <= 32'd0;
            if (r_note_idx != 3'd7) begin
              r_note_idx <= r_note_idx + 3'd1;
              r_state    <= S_PLAY;
            end else begin
              r_done <= 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
              r_note_idx <= 3'd0;
              r_state    <= S_PLAY;
`else
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tone  <= 1'b0;
        end
      endcase
    end
  end

  assign sif.tone_out = r_tone;
  assign sif.busy     = r_busy;
  assign sif.note_idx = r_note_idx;
  assign sif.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
//==============================================================================
// Module      : tb_note_sequencer
// Description : Self-checking bench for note_sequencer against a behavioural
//               model of the scale/tone rules; honours NOTE_SEQ_LOOP_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_note_sequencer;

  localparam int DUR  = 60;
  localparam int GAP  = 5;
  localparam int DUR2 = 50000;
`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  note_sequencer_if sif();
  note_sequencer_if sif2();

  note_sequencer #(.DUR_CYCLES(DUR), .GAP_CYCLES(GAP)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .sif      (sif)
  );

  note_sequencer #(.DUR_CYCLES(DUR2), .GAP_CYCLES(3)) dut2 (
    .CLOCK_50 (clk),
    .reset_n  (rst2_n),
    .sif      (sif2)
  );

  int n_vec = 0;
  int n_err = 0;

  longint rom [8] = '{47774, 42586, 37933, 35814, 31885, 28407, 25307, 23888};

  // behavioural model: phase plus elapsed-time arithmetic
  typedef enum int {M_IDLE, M_MAN, M_PLAY, M_GAP} mph_t;
  mph_t   m_ph   = M_IDLE;
  longint m_t    = 0;
  longint m_k    = 0;
  longint m_segd = 0;
  longint m_prev = 0;
  int     m_idx  = 0;
  bit     m_lvl0 = 1'b0;
  bit     m_done = 1'b0;
  bit     m_cur;
  int     cyc = 0;

  function automatic bit f_tone();
    if (m_ph == M_MAN)
      return (m_segd == 0) ? 1'b0 : (m_lvl0 ^ bit'((m_k / m_segd) & 1));
    if (m_ph == M_PLAY)
      return bit'((m_t / rom[m_idx]) & 1);
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = M_IDLE; m_t = 0; m_k = 0; m_segd = 0; m_prev = 0;
      m_idx = 0; m_lvl0 = 0; m_done = 0;
    end else begin
      m_cur  = f_tone();
      m_done = 1'b0;
      case (m_ph)
        M_IDLE:
          if (sif.start && !sif.stop) begin
            if (sif.mode) begin m_ph = M_PLAY; m_idx = 0; m_t = 0; end
            else begin m_ph = M_MAN; m_k = 0; m_lvl0 = 0; m_segd = longint'(sif.div_in); end
          end
        M_MAN:
          if (sif.stop) m_ph = M_IDLE;
          else if (longint'(sif.div_in) != m_prev) begin
            m_lvl0 = m_cur; m_k = 0; m_segd = longint'(sif.div_in);
          end else m_k++;
        M_PLAY:
          if (sif.stop) m_ph = M_IDLE;
          else begin
            m_t++;
            if (m_t == DUR) begin m_ph = M_GAP; m_t = 0; end
          end
        M_GAP:
          if (sif.stop) m_ph = M_IDLE;
          else begin
            m_t++;
            if (m_t == GAP) begin
              m_t = 0;
              if (m_idx < 7) begin m_idx++; m_ph = M_PLAY; end
              else begin
                m_done = 1'b1;
                if (LOOP) begin m_idx = 0; m_ph = M_PLAY; end
                else m_ph = M_IDLE;
              end
            end
          end
        default: m_ph = M_IDLE;
      endcase
      m_prev = longint'(sif.div_in);
    end
    #1;
    cyc++;
    n_vec++;
    if (sif.tone_out !== f_tone() || sif.busy !== (m_ph != M_IDLE) ||
        int'(sif.note_idx) != m_idx || sif.done !== m_done) begin
      n_err++;
      $display("FAIL model cycle %0d: tone/busy/idx/done got %b/%b/%0d/%b expected %b/%b/%0d/%b",
               cyc, sif.tone_out, sif.busy, sif.note_idx, sif.done,
               f_tone(), (m_ph != M_IDLE), m_idx, m_done);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idx(input int idx);
    int c = 0;
    while (int'(sif.note_idx) != idx && c < 2000) begin step(1); c++; end
    chk($sformatf("reach_note%0d", idx), sif.note_idx, idx);
  endtask

  initial begin
    int c;
    sif.start = 0; sif.stop = 0; sif.mode = 0; sif.div_in = 0;
    sif2.start = 0; sif2.stop = 0; sif2.mode = 0; sif2.div_in = 0;
    step(3);
    rst_n = 1'b1; rst2_n = 1'b1;
    chk("reset_busy", sif.busy, 0);
    chk("reset_tone", sif.tone_out, 0);
    chk("reset_idx", sif.note_idx, 0);
    chk("reset_done", sif.done, 0);
    fork
      begin : g_rom0
        int c2 = 0;
        sif2.mode = 1; sif2.start = 1;
        step(1);
        sif2.start = 0; sif2.mode = 0;
        while (!sif2.tone_out && c2 < 60000) begin step(1); c2++; end
        chk("note0_half_period", c2, 47774);
        chk("note0_idx", sif2.note_idx, 0);
      end
      begin : g_main
        // manual tone, divisor 4
        sif.div_in = 4; step(1);
        sif.start = 1; step(1); sif.start = 0;
        chk("manual_busy", sif.busy, 1);
        c = 0; while (!sif.tone_out && c < 100) begin step(1); c++; end
        chk("manual_first_rise", c, 4);
        c = 0; do begin step(1); c++; end while (sif.tone_out && c < 100);
        while (!sif.tone_out && c < 100) begin step(1); c++; end
        chk("manual_period", c, 8);
        // divisor 4 -> 6 two cycles into the high half
        step(2); sif.div_in = 6;
        c = 0; while (sif.tone_out && c < 100) begin step(1); c++; end
        chk("div_change_hold", c, 1 + 6);
        c = 0; while (!sif.tone_out && c < 100) begin step(1); c++; end
        while (sif.tone_out && c < 100) begin step(1); c++; end
        chk("div6_period", c, 12);
        sif.stop = 1; step(1); sif.stop = 0;
        chk("manual_stop_busy", sif.busy, 0);
        chk("manual_stop_tone", sif.tone_out, 0);
        sif.start = 1; sif.stop = 1; step(1); sif.start = 0; sif.stop = 0;
        chk("start_stop_idle", sif.busy, 0);
        step(1);
        chk("start_stop_idle2", sif.busy, 0);

        // full automatic scale
        sif.mode = 1; sif.start = 1; step(1); sif.start = 0; sif.mode = 0;
        chk("auto_idx0", sif.note_idx, 0);
        chk("auto_busy", sif.busy, 1);
        c = 0; while (!sif.done && c < 2000) begin step(1); c++; end
        chk("scale_length", c, 8 * (DUR + GAP));
        chk("scale_end_busy", sif.busy, LOOP ? 1 : 0);
        chk("scale_end_idx", sif.note_idx, LOOP ? 0 : 7);
        step(1);
        chk("done_one_cycle", sif.done, 0);
        if (LOOP) begin
          c = 1; while (!sif.done && c < 2000) begin step(1); c++; end
          chk("second_pass_length", c, 8 * (DUR + GAP));
          sif.stop = 1; step(1); sif.stop = 0;
          chk("loop_stop_busy", sif.busy, 0);
        end

        // stop at cycle 50 of note 3
        sif.mode = 1; sif.start = 1; step(1); sif.start = 0; sif.mode = 0;
        wait_idx(3);
        step(50); sif.stop = 1; step(1); sif.stop = 0;
        chk("stop_busy", sif.busy, 0);
        chk("stop_tone", sif.tone_out, 0);
        chk("stop_idx_hold", sif.note_idx, 3);
        chk("stop_no_done", sif.done, 0);

        // reset during the gap after note 5
        sif.mode = 1; sif.start = 1; step(1); sif.start = 0; sif.mode = 0;
        wait_idx(5);
        step(DUR + 2);
        rst_n = 1'b0; #1;
        chk("rst_busy", sif.busy, 0);
        chk("rst_idx", sif.note_idx, 0);
        chk("rst_tone", sif.tone_out, 0);
        step(3); rst_n = 1'b1;
        step(2);
        chk("no_auto_resume", sif.busy, 0);
        sif.mode = 1; sif.start = 1; step(1); sif.start = 0; sif.mode = 0;
        chk("restart_idx", sif.note_idx, 0);
        chk("restart_busy", sif.busy, 1);
        sif.stop = 1; step(1); sif.stop = 0;

        // randomized traffic
        for (int i = 0; i < 8000; i++) begin
          rst_n      = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
          sif.start  = ($urandom_range(0, 99) < 4);
          sif.stop   = ($urandom_range(0, 999) < 3);
          sif.mode   = $urandom_range(0, 1);
          if ($urandom_range(0, 99) < 5) sif.div_in = $urandom_range(0, 12);
          step(1);
        end
        rst_n = 1'b1; sif.start = 0; sif.stop = 0;
        step(2);
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
